// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, opcode range
// helpers and the controller state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  // Shift ops occupy a contiguous block; everything above the last shift is illegal.
  localparam logic [3:0] OP_SHIFT_LO = OP_SLL;
  localparam logic [3:0] OP_SHIFT_HI = OP_SRA;
  localparam logic [3:0] OP_LEGAL_HI = OP_SRA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Only shift ops produce a meaningful carry; other ops leave the ALU flag stale.
  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_SHIFT_LO) && (op <= OP_SHIFT_HI);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LEGAL_HI;
  endfunction

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// Two-requester round-robin arbiter. pointer holds the index of the requester
// granted last; on contention the other requester wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  input  logic       enable,
  output logic [1:0] grant
);

  // One-hot grant, zero when disabled or nobody is requesting.
  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = pointer ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

endmodule

// File: rtl/alu_arb.sv
// Arbitrates two requesters onto one shared, externally registered ALU and
// returns each result on a single response channel tagged with the requester id.
module alu_arb
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_tr,
  output logic [31:0] alu_sr,
  input  logic [31:0] alu_dr,
  input  logic        alu_cf,
  input  logic        alu_of,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_cf,
  output logic        rsp_of,
  output logic        rsp_err
);

  state_e      state_q;
  logic        last_q;
  logic        id_q;
  logic [3:0]  alu_op_q;
  logic [31:0] alu_tr_q;
  logic [31:0] alu_sr_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic        rsp_cf_q;
  logic        rsp_of_q;
  logic        rsp_err_q;

  logic [1:0]  grant;
  logic        accept;
  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .pointer (last_q),
    .enable  (state_q == ST_IDLE),
    .grant   (grant)
  );

  // Grants are only ever raised for a valid requester, so any grant is an accept.
  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_op     = grant[1] ? req1_op : req0_op;
  assign sel_a      = grant[1] ? req1_a  : req0_a;
  assign sel_b      = grant[1] ? req1_b  : req0_b;

  // Controller FSM: accept, drive ALU, wait one cycle, capture, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      alu_op_q    <= OP_ADD;
      alu_tr_q    <= '0;
      alu_sr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cf_q    <= 1'b0;
      rsp_of_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            last_q <= grant[1];
            id_q   <= grant[1];
            if (is_legal(sel_op)) begin
              alu_op_q <= sel_op;
              alu_tr_q <= sel_a;
              alu_sr_q <= sel_b;
              state_q  <= ST_EXEC;
            end else begin
              // Illegal op bypasses the ALU and answers straight away with an error.
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= grant[1];
              rsp_data_q  <= '0;
              rsp_cf_q    <= 1'b0;
              rsp_of_q    <= 1'b0;
              rsp_err_q   <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_EXEC: state_q <= ST_CAPT;
        ST_CAPT: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_data_q  <= alu_dr;
          rsp_cf_q    <= is_shift(alu_op_q) ? alu_cf : 1'b0;
          rsp_of_q    <= alu_of;
          rsp_err_q   <= 1'b0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_tr    = alu_tr_q;
  assign alu_sr    = alu_sr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cf    = rsp_cf_q;
  assign rsp_of    = rsp_of_q;
  assign rsp_err   = rsp_err_q;

endmodule
